// File: rtl/rf_writeback_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter_pkg
//   Shared constants for the register-file write-back front end.
//   RF_AW     : register address width
//   RF_DW     : register data width
//   RF_DEPTH  : default long-latency result FIFO depth
//   REG_ZERO  : hard-wired zero register (writes to it are dropped)
// ---------------------------------------------------------------------------
package rf_writeback_arbiter_pkg;

   localparam int unsigned RF_AW    = 5;
   localparam int unsigned RF_DW    = 32;
   localparam int unsigned RF_DEPTH = 4;

   localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

endpackage : rf_writeback_arbiter_pkg

// File: rtl/rf_writeback_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
//   DEPTH-entry synchronous FIFO holding {addr,data} long-latency results.
//   Ports:
//     clk    : clock, state updates on posedge
//     reset  : asynchronous active-low reset (clears pointers and count)
//     push   : write wdata at posedge (ignored when full)
//     pop    : advance read pointer at posedge (ignored when empty)
//     wdata  : entry to store
//     rdata  : current head entry (valid when !empty)
//     full   : count == DEPTH
//     empty  : count == 0
// ---------------------------------------------------------------------------
module rf_wb_fifo
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = RF_DEPTH,
   parameter int unsigned W     = RF_AW + RF_DW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [W-1:0]  mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule : rf_wb_fifo

// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//   Front end for the register-file write port. Merges single-cycle WB
//   writes with queued long-latency results and tracks registers that
//   still await a long-latency result (pending-write scoreboard).
//   Ports:
//     clk, reset            : clock / asynchronous active-low reset
//     wb_valid/addr/data    : WB stage write (always accepted, has priority)
//     lat_valid/addr/data   : long-latency result, handshake with lat_ready
//     lat_ready             : FIFO not full
//     sb_set/sb_addr        : mark register as awaiting long-latency write
//     q_addr1/2, q_busy1/2  : hazard query ports (combinational)
//     rf_wr/addr/data       : register-file write port (sampled on negedge)
//     drained               : FIFO empty and no register pending
//     waw_err               : sticky, WB wrote a pending register
// ---------------------------------------------------------------------------
module rf_writeback_arbiter
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = RF_DEPTH,
   parameter int unsigned AW    = RF_AW,
   parameter int unsigned DW    = RF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          lat_valid,
   output logic          lat_ready,
   input  logic [AW-1:0] lat_addr,
   input  logic [DW-1:0] lat_data,
   input  logic          sb_set,
   input  logic [AW-1:0] sb_addr,
   input  logic [AW-1:0] q_addr1,
   output logic          q_busy1,
   input  logic [AW-1:0] q_addr2,
   output logic          q_busy2,
   output logic          rf_wr,
   output logic [AW-1:0] rf_addr,
   output logic [DW-1:0] rf_data,
   output logic          drained,
   output logic          waw_err
);

   localparam int unsigned NREG = 2 ** AW;
   localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic          wb_take;

   // Bit 0 is never set, so the zero register never reads as busy.
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   assign wb_take   = wb_valid && (wb_addr != ZERO);
   assign lat_ready = !fifo_full;
   // Results for the zero register complete the handshake but are dropped.
   assign fifo_push = lat_valid && lat_ready && (lat_addr != ZERO);
   assign fifo_pop  = reset && !wb_take && !fifo_empty;

   rf_wb_fifo #(
      .DEPTH (DEPTH),
      .W     (AW + DW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata ({lat_addr, lat_data}),
      .rdata ({head_addr, head_data}),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Write selection; gated by reset so nothing reaches the RF while held.
   always_comb begin
      rf_wr   = 1'b0;
      rf_addr = '0;
      rf_data = '0;
      if (reset) begin
         if (wb_take) begin
            rf_wr   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
         end else if (!fifo_empty) begin
            rf_wr   = 1'b1;
            rf_addr = head_addr;
            rf_data = head_data;
         end
      end
   end

   // Clear on pop first, then set, so a same-cycle set of that register wins.
   always_comb begin
      busy_next = busy;
      if (fifo_pop)
         busy_next[head_addr] = 1'b0;
      if (sb_set && (sb_addr != ZERO))
         busy_next[sb_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy    <= '0;
         waw_err <= 1'b0;
      end else begin
         busy <= busy_next;
         if (wb_take && busy[wb_addr])
            waw_err <= 1'b1;
      end
   end

   assign q_busy1 = (q_addr1 != ZERO) && busy[q_addr1];
   assign q_busy2 = (q_addr2 != ZERO) && busy[q_addr2];
   assign drained = fifo_empty && (busy == '0);

endmodule : rf_writeback_arbiter

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;

   localparam int unsigned D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        lat_valid;
   logic        lat_ready;
   logic [4:0]  lat_addr;
   logic [31:0] lat_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [4:0]  q_addr1;
   logic        q_busy1;
   logic [4:0]  q_addr2;
   logic        q_busy2;
   logic        rf_wr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        drained;
   logic        waw_err;

   always #5 clk = ~clk;

   rf_writeback_arbiter #(
      .DEPTH (D),
      .AW    (5),
      .DW    (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .lat_valid (lat_valid),
      .lat_ready (lat_ready),
      .lat_addr  (lat_addr),
      .lat_data  (lat_data),
      .sb_set    (sb_set),
      .sb_addr   (sb_addr),
      .q_addr1   (q_addr1),
      .q_busy1   (q_busy1),
      .q_addr2   (q_addr2),
      .q_busy2   (q_busy2),
      .rf_wr     (rf_wr),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .drained   (drained),
      .waw_err   (waw_err)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pending results in arrival order, pending-register set,
   // sticky write-after-write flag.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;
   ent_t mq[$];
   bit   mbusy[32];
   bit   mwaw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      mwaw = 1'b0;
   endtask

   // One clock cycle: drive inputs just after posedge, compare at negedge,
   // advance the model to what the next posedge should produce.
   task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic sbs, input logic [4:0] sba,
                       input logic [4:0] q1, input logic [4:0] q2,
                       output bit accepted);
      bit          take;
      int          sz;
      bit          any_busy;
      logic [4:0]  ea;
      logic [31:0] ed;
      wb_valid = wv; wb_addr = wa; wb_data = wd;
      lat_valid = lv; lat_addr = la; lat_data = ld;
      sb_set = sbs; sb_addr = sba;
      q_addr1 = q1; q_addr2 = q2;
      @(negedge clk);
      take = wv && (wa != 5'd0);
      sz   = mq.size();
      ea   = 5'd0;
      ed   = 32'd0;
      if (take) begin
         ea = wa; ed = wd;
      end else if (sz > 0) begin
         ea = mq[0].a; ed = mq[0].d;
      end
      any_busy = 1'b0;
      for (int i = 0; i < 32; i++) if (mbusy[i]) any_busy = 1'b1;
      chk("rf_wr",     32'(rf_wr),     32'(take || (sz > 0)));
      chk("rf_addr",   32'(rf_addr),   32'(ea));
      chk("rf_data",   rf_data,        ed);
      chk("lat_ready", 32'(lat_ready), 32'(sz < D));
      chk("q_busy1",   32'(q_busy1),   32'((q1 != 5'd0) && mbusy[q1]));
      chk("q_busy2",   32'(q_busy2),   32'((q2 != 5'd0) && mbusy[q2]));
      chk("drained",   32'(drained),   32'((sz == 0) && !any_busy));
      chk("waw_err",   32'(waw_err),   32'(mwaw));
      accepted = lv && (sz < D);
      if (take && mbusy[wa]) mwaw = 1'b1;
      if (!take && sz > 0) begin
         mbusy[mq[0].a] = 1'b0;
         void'(mq.pop_front());
      end
      if (lv && (sz < D) && (la != 5'd0)) mq.push_back('{a: la, d: ld});
      if (sbs && (sba != 5'd0)) mbusy[sba] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [4:0] q1);
      bit acc;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, q1, 0, acc);
   endtask

   // Reset asserted mid-cycle while WB is requesting a write.
   task automatic apply_reset(input logic [4:0] q1);
      #2;
      reset    = 1'b0;
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
      lat_valid = 1'b0; lat_addr = 5'd0; lat_data = 32'd0;
      sb_set = 1'b0; sb_addr = 5'd0;
      q_addr1 = q1; q_addr2 = 5'd0;
      @(negedge clk);
      chk("rst_rf_wr",     32'(rf_wr),     32'd0);
      chk("rst_rf_addr",   32'(rf_addr),   32'd0);
      chk("rst_rf_data",   rf_data,        32'd0);
      chk("rst_lat_ready", 32'(lat_ready), 32'd1);
      chk("rst_drained",   32'(drained),   32'd1);
      chk("rst_q_busy1",   32'(q_busy1),   32'd0);
      chk("rst_waw_err",   32'(waw_err),   32'd0);
      model_clear();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      bit acc;
      int n;
      logic [4:0] la;

      model_clear();
      reset = 1'b1;
      wb_valid = 0; wb_addr = 0; wb_data = 0;
      lat_valid = 0; lat_addr = 0; lat_data = 0;
      sb_set = 0; sb_addr = 0; q_addr1 = 0; q_addr2 = 0;
      @(posedge clk);
      #1;
      apply_reset(5'd0);
      idle(1, 5'd0);

      // Single long-latency result reaches the RF the cycle after acceptance.
      step(0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 0, acc);
      step(0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 5'd5, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 0, acc);

      // Continuous WB to r3 holds off a queued r7 result.
      step(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 5'd7, 5'd7, 5'd3, acc);
      for (int i = 0; i < 4; i++) step(1, 5'd3, 32'h300 + i, 0, 0, 0, 0, 0, 5'd7, 0, acc);
      idle(2, 5'd7);

      // Fill the FIFO under continuous WB; fifth result waits for a pop.
      la = 5'd10;
      n  = 0;
      while (n < 8) begin
         step(1, 5'd3, 32'h3000 + n, (la <= 5'd14), la, 32'hA000 + la, 0, 0, 5'd10, 5'd14, acc);
         if (acc) la = la + 5'd1;
         n++;
      end
      for (int i = 0; i < 8 && la <= 5'd14; i++) begin
         step(0, 0, 0, 1, la, 32'hA000 + la, 0, 0, 5'd10, 5'd14, acc);
         if (acc) la = la + 5'd1;
      end
      idle(6, 5'd14);

      // Set of r9 in the same cycle its pending result pops: set wins.
      step(0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 0, acc);
      step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0, acc);
      step(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9, acc);

      // WB to a pending register sets the sticky error; zero-register writes dropped.
      step(0, 0, 0, 0, 0, 0, 1, 5'd4, 5'd4, 0, acc);
      step(1, 5'd4, 32'hAA, 0, 0, 0, 0, 0, 5'd4, 0, acc);
      step(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 0, 0, 5'd4, 0, acc);
      idle(3, 5'd4);

      // Randomized traffic with frequent address collisions.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 2) == 0,
              5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      end
      idle(8, 5'd0);

      // Reset with two results queued and r20/r21 pending.
      step(1, 5'd3, 32'h1, 1, 5'd20, 32'h20, 1, 5'd20, 5'd20, 0, acc);
      step(1, 5'd3, 32'h2, 1, 5'd21, 32'h21, 1, 5'd21, 5'd20, 0, acc);
      apply_reset(5'd20);
      idle(4, 5'd21);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rf_writeback_arbiter
